ulpi_phy_emu: RTL and testbench
===============================

Name: ulpi_phy_emu

Overview:
- Synthesisable PHY-side endpoint of the ULPI link. Drives dir/nxt, receives stp, and owns the data bus whenever dir is high.
- Lets the USB link core be exercised in loopback or on-FPGA without a real PHY:
  - packets on the slave AXI4-Stream are presented to the link as USB RX traffic;
  - link transmit packets appear on the master AXI4-Stream.
- Implements ULPI register write/read, RX CMD generation, and a 16-byte register file.

Parameters:
- VENDOR_ID, 16'h0424, returned at register addresses 0x00 (low byte) and 0x01 (high byte).
- PRODUCT_ID, 16'h0009, returned at register addresses 0x02 (low byte) and 0x03 (high byte).

Ports:
- clock  in  1  ULPI 60 MHz clock; all logic on posedge.
- areset_n  in  1  asynchronous, active-low reset.
- ulpi_dir_o  out  1  PHY owns bus when high.
- ulpi_nxt_o  out  1  PHY next/throttle.
- ulpi_stp_i  in  1  link stop.
- ulpi_data_i  in  8  bus value driven by link (dir=0).
- ulpi_data_o  out  8  bus value driven by PHY (meaningful only when dir=1).
- linestate_i  in  2  emulated LineState.
- vbus_state_i  in  2  emulated VbusState.
- s_axis_tvalid_i / s_axis_tready_o / s_axis_tlast_i / s_axis_tdata_i[8]  in/out/in/in  1/1/1/8  USB RX packet (PID first) to link.
- m_axis_tvalid_o / m_axis_tready_i / m_axis_tlast_o / m_axis_tdata_o[8]  out/in/out/out  1/1/1/8  link TX packet, full PID byte first.
- func_ctrl_o  out  8  register 0x04 contents.
- otg_ctrl_o  out  8  register 0x0A contents.

Behaviour:
- Reset values:
  - dir=0, nxt=0, data_o=0x00, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0x00.
  - Register 0x04=0x41, register 0x0A=0x06, all other writable registers=0x00.
  - Reset mid-operation returns to IDLE immediately with these values.
- RX CMD byte = {2'b00, rxevent[1:0], vbus_state_i, linestate_i}.
  - rxevent: 01 while an RX packet is active, otherwise 00.
- FSM states: IDLE, RXC_TURN, RXC_BYTE, RXC_END, RX_TURN, RX_DATA, RX_END, RX_BACK, TXC_ACK, TX_DATA, REGW_DATA, REGW_STP, REGR_TURN, REGR_DATA, REGR_BACK.
- IDLE priority, highest first:
  1. s_tvalid;
  2. link TX CMD (ulpi_data_i != 0);
  3. change in {linestate_i, vbus_state_i} since the last RX CMD sent.
  - If s_tvalid and a TX CMD coincide, RX wins: the link aborts per ULPI, and the TX CMD is ignored.
- RX packet:
  - RX_TURN: dir=1, nxt=1, data_o=0x00 for one cycle.
  - RX_DATA: s_tready=1. Each beat accepted shows data_o=tdata with nxt=1 in the following cycle.
  - If tvalid drops mid-packet, output RX CMD with rxevent=01 and nxt=0 for each gap cycle.
  - After the tlast beat is shown, RX_END outputs one RX CMD with rxevent=00 and nxt=0.
  - RX_BACK: dir=0 turnaround for one cycle, then IDLE.
- Standalone RX CMD:
  - RXC_TURN: dir=1, nxt=0 for one cycle.
  - RXC_BYTE: RX CMD byte for one cycle.
  - RXC_END: dir=0 for one cycle.
  - Latches the reported state.
- Link transmit (TX CMD 8'b0100_PPPP):
  - TXC_ACK: nxt=1 for one cycle; captures {~P, P} as the first output byte.
  - TX_DATA: the byte on ulpi_data_i is taken on each edge where nxt=1 and stp=0.
  - nxt = ~hold_valid | m_tready, using a one-byte hold register so tlast can be attached.
  - stp=1 ends the packet: the held byte is emitted with tlast=1, and the bus byte in the stp cycle is discarded. A PID-only packet yields one byte with tlast=1.
  - m_axis obeys AXI-S: data stable while tvalid & ~tready.
- Register write (8'b10AA_AAAA):
  - TXC_ACK: nxt=1.
  - REGW_DATA: nxt=1; data is captured.
  - REGW_STP: the write commits on the edge where stp=1, then IDLE.
  - If stp is not seen in REGW_STP, the write is dropped and the FSM returns to IDLE.
  - 0x05/0x06 are set/clear aliases of 0x04; 0x0B/0x0C are set/clear aliases of 0x0A.
  - Addresses 0x00–0x03 and 0x10–0x3F ignore writes.
- Register read (8'b11AA_AAAA):
  - TXC_ACK: nxt=1.
  - REGR_TURN: dir=1, nxt=0.
  - REGR_DATA: data_o=reg.
  - REGR_BACK: dir=0.
  - 0x05/0x06 read as 0x04; 0x0B/0x0C read as 0x0A; unmapped addresses read 0x00.
- TX CMD 8'b00xx_xxxx other than 0x00 is ignored (treated as idle).
- Link stp asserted in any PHY-owned state is ignored.

Test Plan:
- Register write 0x84, 0x45, then stp → func_ctrl_o=0x45 on the cycle after stp.
- Register read 0xC1 → nxt=1 for one cycle, then turnaround, then data_o=0x04 (VENDOR_ID high byte), then dir=0; read 0xE0 → 0x00.
- Set alias: write 0x85 with 0x02 → func_ctrl_o=0x43. Clear alias: write 0x86 with 0x40 → func_ctrl_o=0x03.
- Link TX: 0x43, 0x11, 0x22, then stp → m_axis beats C3, 11, 22(tlast). With m_tready held low 4 cycles, nxt drops and no byte is lost.
- s_axis packet C3, AA, BB(tlast), with tvalid gap after AA:
  - dir/nxt=1 turnaround;
  - bytes C3, AA with nxt=1;
  - RX CMD 0x1x with nxt=0 during the gap;
  - BB with nxt=1;
  - RX CMD 0x0x with nxt=0;
  - dir=0.
- linestate_i 01→10 in IDLE → dir pulse with RX CMD 0x02 (vbus=0). A simultaneous s_tvalid and TX CMD 0x84 → RX sequence starts and no register changes.

Source files
------------

// File: rtl/ulpi_phy_emu_if.sv
// ULPI link-side bus plus the two AXI4-Stream packet ports of the PHY emulator.
//   master : PHY side (ulpi_phy_emu) - drives dir/nxt/data_o, s_axis ready, m_axis beat
//   slave  : link/environment side   - drives stp/data_i, s_axis beat, m_axis ready
interface ulpi_phy_emu_if;
  logic       ulpi_dir_o;
  logic       ulpi_nxt_o;
  logic       ulpi_stp_i;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       s_axis_tvalid_i;
  logic       s_axis_tready_o;
  logic       s_axis_tlast_i;
  logic [7:0] s_axis_tdata_i;
  logic       m_axis_tvalid_o;
  logic       m_axis_tready_i;
  logic       m_axis_tlast_o;
  logic [7:0] m_axis_tdata_o;

  modport master (
    output ulpi_dir_o, ulpi_nxt_o, ulpi_data_o,
    output s_axis_tready_o,
    output m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o,
    input  ulpi_stp_i, ulpi_data_i,
    input  s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i,
    input  m_axis_tready_i
  );

  modport slave (
    input  ulpi_dir_o, ulpi_nxt_o, ulpi_data_o,
    input  s_axis_tready_o,
    input  m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o,
    output ulpi_stp_i, ulpi_data_i,
    output s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i,
    output m_axis_tready_i
  );
endinterface

// File: rtl/ulpi_phy_emu.sv
// ULPI PHY emulator: PHY-side endpoint of a ULPI link for loopback / on-FPGA use.
//   clock, areset_n : 60 MHz ULPI clock, async active-low reset
//   bus (master)    : ULPI dir/nxt/stp/data, s_axis (USB RX packets to the link),
//                     m_axis (link TX packets, full PID byte first)
//   linestate_i     : emulated LineState
//   vbus_state_i    : emulated VbusState
//   func_ctrl_o     : register 0x04 (Function Control)
//   otg_ctrl_o      : register 0x0A (OTG Control)
// Handles register write/read, RX CMD reporting of line/vbus changes, and
// packet transfer in both directions.
module ulpi_phy_emu #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic           clock,
  input  logic           areset_n,
  ulpi_phy_emu_if.master bus,
  input  logic [1:0]     linestate_i,
  input  logic [1:0]     vbus_state_i,
  output logic [7:0]     func_ctrl_o,
  output logic [7:0]     otg_ctrl_o
);

  typedef enum logic [3:0] {
    IDLE, RXC_TURN, RXC_BYTE, RXC_END,
    RX_TURN, RX_DATA, RX_END, RX_BACK,
    TXC_ACK, TX_DATA,
    REGW_DATA, REGW_STP,
    REGR_TURN, REGR_DATA, REGR_BACK
  } state_t;

  state_t           state;
  logic             dir_r, nxt_r;
  logic [7:0]       data_r;
  logic             s_tready_r;
  logic             rx_last_r;   // tlast beat accepted, now being shown
  logic [1:0]       cmd_r;       // TX CMD class: 01 tx, 10 regw, 11 regr
  logic [5:0]       addr_r;      // register address or {2'b00, PID}
  logic [7:0]       wdata_r;
  logic [3:0]       last_rpt_r;  // {vbus, linestate} of the last RX CMD sent
  logic [7:0]       hold_r;
  logic             hold_vld_r;
  logic             stp_seen_r;  // stp arrived while m_axis was still busy
  logic             m_tvalid_r, m_tlast_r;
  logic [7:0]       m_tdata_r;
  logic [15:0][7:0] regs;
  logic [7:0]       rd_val;

  logic [3:0] line_now;
  logic       s_beat, out_free, tx_nxt, tx_take;

  function automatic logic [7:0] rx_cmd(input logic active, input logic [3:0] line);
    return {2'b00, 1'b0, active, line};
  endfunction

  assign line_now = {vbus_state_i, linestate_i};
  assign s_beat   = bus.s_axis_tvalid_i & s_tready_r;
  assign out_free = ~m_tvalid_r | bus.m_axis_tready_i;
  // Throttle: a new byte may only land if the held one can move to m_axis.
  assign tx_nxt   = ~stp_seen_r & (~hold_vld_r | bus.m_axis_tready_i);
  assign tx_take  = (state == TX_DATA) & tx_nxt & ~bus.ulpi_stp_i;

  assign bus.ulpi_dir_o      = dir_r;
  assign bus.ulpi_nxt_o      = (state == TX_DATA) ? tx_nxt : nxt_r;
  assign bus.ulpi_data_o     = data_r;
  assign bus.s_axis_tready_o = s_tready_r;
  assign bus.m_axis_tvalid_o = m_tvalid_r;
  assign bus.m_axis_tlast_o  = m_tlast_r;
  assign bus.m_axis_tdata_o  = m_tdata_r;
  assign func_ctrl_o         = regs[4];
  assign otg_ctrl_o          = regs[10];

  // Register read mux; set/clear aliases read back their base register.
  always_comb begin
    rd_val = 8'h00;
    case (addr_r)
      6'h00: rd_val = VENDOR_ID[7:0];
      6'h01: rd_val = VENDOR_ID[15:8];
      6'h02: rd_val = PRODUCT_ID[7:0];
      6'h03: rd_val = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: rd_val = regs[4];
      6'h0A, 6'h0B, 6'h0C: rd_val = regs[10];
      6'h07, 6'h08, 6'h09,
      6'h0D, 6'h0E, 6'h0F: rd_val = regs[addr_r[3:0]];
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      dir_r      <= 1'b0;
      nxt_r      <= 1'b0;
      data_r     <= 8'h00;
      s_tready_r <= 1'b0;
      rx_last_r  <= 1'b0;
      cmd_r      <= 2'b00;
      addr_r     <= 6'h00;
      wdata_r    <= 8'h00;
      last_rpt_r <= 4'h0;
      hold_r     <= 8'h00;
      hold_vld_r <= 1'b0;
      stp_seen_r <= 1'b0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tdata_r  <= 8'h00;
      regs       <= '0;
      regs[4]    <= 8'h41;
      regs[10]   <= 8'h06;
    end else begin
      if (m_tvalid_r && bus.m_axis_tready_i) begin
        m_tvalid_r <= 1'b0;
        m_tlast_r  <= 1'b0;
      end

      case (state)
        IDLE: begin
          dir_r  <= 1'b0;
          nxt_r  <= 1'b0;
          data_r <= 8'h00;
          // RX beats a coincident TX CMD: the link aborts once dir rises.
          if (bus.s_axis_tvalid_i) begin
            state      <= RX_TURN;
            dir_r      <= 1'b1;
            nxt_r      <= 1'b1;
            s_tready_r <= 1'b1;
            rx_last_r  <= 1'b0;
          end else if (bus.ulpi_data_i[7:6] != 2'b00) begin
            state  <= TXC_ACK;
            nxt_r  <= 1'b1;
            cmd_r  <= bus.ulpi_data_i[7:6];
            addr_r <= bus.ulpi_data_i[5:0];
          end else if (line_now != last_rpt_r) begin
            state <= RXC_TURN;
            dir_r <= 1'b1;
          end
        end

        RXC_TURN: begin
          state      <= RXC_BYTE;
          data_r     <= rx_cmd(1'b0, line_now);
          last_rpt_r <= line_now;
        end
        RXC_BYTE: begin
          state  <= RXC_END;
          dir_r  <= 1'b0;
          data_r <= 8'h00;
        end
        RXC_END: state <= IDLE;

        // tready is already up during the turnaround so the first beat is
        // shown in the very next cycle.
        RX_TURN, RX_DATA: begin
          if (rx_last_r) begin
            state      <= RX_END;
            nxt_r      <= 1'b0;
            data_r     <= rx_cmd(1'b0, line_now);
            last_rpt_r <= line_now;
          end else begin
            state <= RX_DATA;
            if (s_beat) begin
              data_r <= bus.s_axis_tdata_i;
              nxt_r  <= 1'b1;
              if (bus.s_axis_tlast_i) begin
                s_tready_r <= 1'b0;
                rx_last_r  <= 1'b1;
              end
            end else begin
              data_r     <= rx_cmd(1'b1, line_now);
              nxt_r      <= 1'b0;
              last_rpt_r <= line_now;
            end
          end
        end
        RX_END: begin
          state  <= RX_BACK;
          dir_r  <= 1'b0;
          data_r <= 8'h00;
        end
        RX_BACK: state <= IDLE;

        TXC_ACK: begin
          case (cmd_r)
            2'b01: begin
              state      <= TX_DATA;
              nxt_r      <= 1'b0;
              hold_r     <= {~addr_r[3:0], addr_r[3:0]};
              hold_vld_r <= 1'b1;
              stp_seen_r <= 1'b0;
            end
            2'b10:   state <= REGW_DATA;
            2'b11: begin
              state <= REGR_TURN;
              dir_r <= 1'b1;
              nxt_r <= 1'b0;
            end
            default: begin
              state <= IDLE;
              nxt_r <= 1'b0;
            end
          endcase
        end

        // The hold byte is only released once the next byte (or stp)
        // tells us whether it is the last one.
        TX_DATA: begin
          if (bus.ulpi_stp_i || stp_seen_r) begin
            if (out_free) begin
              m_tvalid_r <= 1'b1;
              m_tdata_r  <= hold_r;
              m_tlast_r  <= 1'b1;
              hold_vld_r <= 1'b0;
              stp_seen_r <= 1'b0;
              state      <= IDLE;
            end else begin
              stp_seen_r <= 1'b1;
            end
          end else if (tx_take) begin
            if (hold_vld_r) begin
              m_tvalid_r <= 1'b1;
              m_tdata_r  <= hold_r;
              m_tlast_r  <= 1'b0;
            end
            hold_r     <= bus.ulpi_data_i;
            hold_vld_r <= 1'b1;
          end
        end

        REGW_DATA: begin
          state   <= REGW_STP;
          nxt_r   <= 1'b0;
          wdata_r <= bus.ulpi_data_i;
        end
        REGW_STP: begin
          state <= IDLE;
          if (bus.ulpi_stp_i) begin
            case (addr_r)
              6'h04, 6'h07, 6'h08, 6'h09,
              6'h0A, 6'h0D, 6'h0E, 6'h0F: regs[addr_r[3:0]] <= wdata_r;
              6'h05: regs[4]  <= regs[4]  |  wdata_r;
              6'h06: regs[4]  <= regs[4]  & ~wdata_r;
              6'h0B: regs[10] <= regs[10] |  wdata_r;
              6'h0C: regs[10] <= regs[10] & ~wdata_r;
              default: ;
            endcase
          end
        end

        REGR_TURN: begin
          state  <= REGR_DATA;
          data_r <= rd_val;
        end
        REGR_DATA: begin
          state  <= REGR_BACK;
          dir_r  <= 1'b0;
          data_r <= 8'h00;
        end
        REGR_BACK: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Bench for ulpi_phy_emu: directed + randomized ULPI link / AXI-S traffic
// checked against a register-file array model and per-packet expected queues.
module tb_ulpi_phy_emu;
  logic       clock = 1'b0;
  logic       areset_n = 1'b0;
  logic [1:0] linestate = 2'b00;
  logic [1:0] vbus = 2'b00;
  logic [7:0] func_ctrl, otg_ctrl;

  ulpi_phy_emu_if bus();

  ulpi_phy_emu dut (
    .clock(clock), .areset_n(areset_n), .bus(bus),
    .linestate_i(linestate), .vbus_state_i(vbus),
    .func_ctrl_o(func_ctrl), .otg_ctrl_o(otg_ctrl)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [7:0] mreg [64];
  logic [3:0] last_rpt;
  logic [7:0] tx_bytes [$];
  logic [7:0] rx_bytes [$];
  logic [8:0] m_q [$];

  always @(posedge clock)
    if (bus.m_axis_tvalid_o && bus.m_axis_tready_i)
      m_q.push_back({bus.m_axis_tlast_o, bus.m_axis_tdata_o});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    mreg[0] = 8'h24; mreg[1] = 8'h04; mreg[2] = 8'h09; mreg[3] = 8'h00;
    mreg[4] = 8'h41; mreg[10] = 8'h06;
  endtask

  function automatic logic [7:0] model_rd(input logic [5:0] a);
    if (a == 6'h05 || a == 6'h06) return mreg[4];
    if (a == 6'h0B || a == 6'h0C) return mreg[10];
    return mreg[a];
  endfunction

  task automatic model_wr(input logic [5:0] a, input logic [7:0] d);
    if (a < 6'h04 || a > 6'h0F) return;
    case (a)
      6'h05: mreg[4]  = mreg[4]  | d;
      6'h06: mreg[4]  = mreg[4]  & ~d;
      6'h0B: mreg[10] = mreg[10] | d;
      6'h0C: mreg[10] = mreg[10] & ~d;
      default: mreg[a] = d;
    endcase
  endtask

  task automatic wait_nxt(input string tag);
    int n = 0;
    do begin @(negedge clock); n++; end while (!bus.ulpi_nxt_o && n < 8);
    chk(tag, bus.ulpi_nxt_o, 1);
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input logic do_stp);
    tick;
    bus.ulpi_data_i = {2'b10, a};
    wait_nxt("regw_ack");
    tick;
    bus.ulpi_data_i = d;
    @(negedge clock);
    chk("regw_data_nxt", bus.ulpi_nxt_o, 1);
    tick;
    bus.ulpi_data_i = 8'h00;
    bus.ulpi_stp_i  = do_stp;
    tick;
    bus.ulpi_stp_i  = 1'b0;
    if (do_stp) model_wr(a, d);
    @(negedge clock);
    chk("func_ctrl", func_ctrl, mreg[4]);
    chk("otg_ctrl", otg_ctrl, mreg[10]);
  endtask

  task automatic reg_read(input logic [5:0] a);
    tick;
    bus.ulpi_data_i = {2'b11, a};
    wait_nxt("regr_ack");
    tick;
    bus.ulpi_data_i = 8'h00;
    @(negedge clock);
    chk("regr_turn", {bus.ulpi_dir_o, bus.ulpi_nxt_o}, 2'b10);
    @(negedge clock);
    chk($sformatf("regr_data_%0h", a), {bus.ulpi_dir_o, bus.ulpi_data_o}, {1'b1, model_rd(a)});
    @(negedge clock);
    chk("regr_back", bus.ulpi_dir_o, 0);
  endtask

  // Link transmit of PID + tx_bytes; stall=1 holds m_tready low for 4 cycles.
  task automatic tx_packet(input logic [3:0] pid, input logic stall);
    logic [8:0] exp_q [$];
    int idx = 0, cyc = 0, n;
    logic done = 1'b0;
    logic nxt_s;
    n = tx_bytes.size();
    m_q.delete();
    exp_q.push_back({1'b0, ~pid, pid});
    foreach (tx_bytes[i]) exp_q.push_back({1'b0, tx_bytes[i]});
    exp_q[exp_q.size()-1][8] = 1'b1;
    tick;
    bus.m_axis_tready_i = 1'b1;
    bus.ulpi_data_i = {4'b0100, pid};
    wait_nxt("tx_ack");
    tick;
    while (!done && cyc < 200) begin
      bus.m_axis_tready_i = stall ? !(cyc >= 1 && cyc <= 4) : ($urandom_range(0, 3) != 0);
      if (idx < n) begin
        bus.ulpi_data_i = tx_bytes[idx];
        bus.ulpi_stp_i  = 1'b0;
      end else begin
        bus.ulpi_data_i = 8'h00;
        bus.ulpi_stp_i  = 1'b1;
      end
      @(negedge clock);
      nxt_s = bus.ulpi_nxt_o;
      if (!bus.ulpi_stp_i) chk("tx_nxt", nxt_s, bus.m_axis_tready_i);
      @(posedge clock);
      if (bus.ulpi_stp_i) done = 1'b1;
      else if (nxt_s) idx++;
      #1;
      cyc++;
    end
    chk("tx_done", done, 1);
    bus.ulpi_stp_i = 1'b0;
    bus.m_axis_tready_i = 1'b1;
    repeat (4) tick;
    chk("tx_len", m_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < m_q.size(); i++)
      chk($sformatf("tx_beat%0d", i), m_q[i], exp_q[i]);
  endtask

  // RX packet of rx_bytes with gap_len idle cycles after beat gap_after.
  task automatic rx_packet(input int gap_after, input int gap_len, input logic [7:0] txcmd);
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    logic [7:0] rxa, rxi;
    int idx = 0, gap_cnt = 0, cyc = 0, n;
    logic seen = 1'b0, beat;
    n = rx_bytes.size();
    rxa = {4'b0001, vbus, linestate};
    rxi = {4'b0000, vbus, linestate};
    exp_q.push_back({1'b1, 8'h00});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, rx_bytes[i]});
      if (i == gap_after) repeat (gap_len) exp_q.push_back({1'b0, rxa});
    end
    exp_q.push_back({1'b0, rxi});
    tick;
    bus.s_axis_tvalid_i = 1'b1;
    bus.s_axis_tdata_i  = rx_bytes[0];
    bus.s_axis_tlast_i  = (n == 1);
    bus.ulpi_data_i     = txcmd;
    while (cyc < 200) begin
      @(negedge clock);
      if (bus.ulpi_dir_o) begin
        seen = 1'b1;
        got_q.push_back({bus.ulpi_nxt_o, bus.ulpi_data_o});
      end else if (seen) break;
      beat = bus.s_axis_tvalid_i && bus.s_axis_tready_o;
      tick;
      cyc++;
      if (seen) bus.ulpi_data_i = 8'h00;
      if (beat) begin
        if (idx == gap_after && gap_len > 0) begin
          bus.s_axis_tvalid_i = 1'b0;
          gap_cnt = gap_len;
        end
        idx++;
        if (idx >= n) bus.s_axis_tvalid_i = 1'b0;
        bus.s_axis_tdata_i = (idx < n) ? rx_bytes[idx] : 8'h00;
        bus.s_axis_tlast_i = (idx == n - 1);
      end else if (gap_cnt > 0) begin
        gap_cnt--;
        if (gap_cnt == 0) bus.s_axis_tvalid_i = 1'b1;
      end
    end
    bus.ulpi_data_i = 8'h00;
    bus.s_axis_tvalid_i = 1'b0;
    chk("rx_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rx_cyc%0d", i), got_q[i], exp_q[i]);
    chk("rx_tready_end", bus.s_axis_tready_o, 0);
    last_rpt = {vbus, linestate};
  endtask

  // Drive a new line/vbus state; expect a standalone RX CMD only on change.
  task automatic line_change(input logic [1:0] ls, input logic [1:0] vb);
    logic expect_cmd;
    int n = 0;
    tick;
    linestate = ls;
    vbus = vb;
    expect_cmd = ({vb, ls} != last_rpt);
    if (expect_cmd) begin
      do begin @(negedge clock); n++; end while (!bus.ulpi_dir_o && n < 8);
      chk("rxc_turn", {bus.ulpi_dir_o, bus.ulpi_nxt_o}, 2'b10);
      @(negedge clock);
      chk("rxc_byte", {bus.ulpi_dir_o, bus.ulpi_data_o}, {1'b1, 4'b0000, vb, ls});
      @(negedge clock);
      chk("rxc_end", bus.ulpi_dir_o, 0);
      last_rpt = {vb, ls};
    end else begin
      repeat (3) begin
        @(negedge clock);
        chk("rxc_none", bus.ulpi_dir_o, 0);
      end
    end
  endtask

  initial begin
    bus.ulpi_stp_i = 1'b0;
    bus.ulpi_data_i = 8'h00;
    bus.s_axis_tvalid_i = 1'b0;
    bus.s_axis_tlast_i = 1'b0;
    bus.s_axis_tdata_i = 8'h00;
    bus.m_axis_tready_i = 1'b1;
    last_rpt = 4'h0;
    model_reset();

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_dir", bus.ulpi_dir_o, 0);
    chk("rst_nxt", bus.ulpi_nxt_o, 0);
    chk("rst_data", bus.ulpi_data_o, 8'h00);
    chk("rst_s_tready", bus.s_axis_tready_o, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid_o, 0);
    chk("rst_m_tlast", bus.m_axis_tlast_o, 0);
    chk("rst_m_tdata", bus.m_axis_tdata_o, 8'h00);
    chk("rst_func", func_ctrl, 8'h41);
    chk("rst_otg", otg_ctrl, 8'h06);
    tick;
    areset_n = 1'b1;
    repeat (2) tick;

    // Aliases from reset value, then a plain write.
    reg_write(6'h05, 8'h02, 1'b1);
    chk("set_alias", func_ctrl, 8'h43);
    reg_write(6'h06, 8'h40, 1'b1);
    chk("clr_alias", func_ctrl, 8'h03);
    reg_write(6'h04, 8'h45, 1'b1);
    chk("func_write", func_ctrl, 8'h45);
    reg_write(6'h0A, 8'hFF, 1'b0);        // no stp: dropped
    reg_write(6'h01, 8'h77, 1'b1);        // ID byte: read-only
    reg_read(6'h01);
    reg_read(6'h20);
    reg_read(6'h05);

    // Reserved 00xx_xxxx command is ignored.
    tick;
    bus.ulpi_data_i = 8'h2A;
    repeat (3) begin
      @(negedge clock);
      chk("ign_cmd", {bus.ulpi_dir_o, bus.ulpi_nxt_o}, 2'b00);
    end
    tick;
    bus.ulpi_data_i = 8'h00;

    // Link transmit: directed with stall, PID-only, random.
    tx_bytes = '{8'h11, 8'h22};
    tx_packet(4'h3, 1'b1);
    tx_bytes.delete();
    tx_packet(4'h5, 1'b0);
    repeat (3) begin
      tx_bytes.delete();
      repeat ($urandom_range(1, 6)) tx_bytes.push_back(8'($urandom));
      tx_packet(4'($urandom), 1'b0);
    end

    // Line state reporting.
    line_change(2'b01, 2'b00);
    line_change(2'b10, 2'b00);
    line_change(2'b10, 2'b00);            // unchanged: no RX CMD
    repeat (3) line_change(2'($urandom), 2'($urandom));

    // RX packets: directed with gap, simultaneous TX CMD, random.
    rx_bytes = '{8'hC3, 8'hAA, 8'hBB};
    rx_packet(1, 2, 8'h00);
    rx_bytes = '{8'h4B, 8'h01};
    rx_packet(-1, 0, 8'h84);
    repeat (2) tick;
    chk("rx_abort_func", func_ctrl, mreg[4]);
    reg_read(6'h04);
    repeat (3) begin
      int n, g;
      rx_bytes.delete();
      n = $urandom_range(1, 6);
      repeat (n) rx_bytes.push_back(8'($urandom));
      g = (n >= 2) ? int'($urandom_range(0, n - 2)) : -1;
      rx_packet(g, $urandom_range(0, 3), 8'h00);
    end

    // Random register traffic against the array model.
    repeat (10) begin
      logic [5:0] a;
      a = 6'($urandom);
      if ($urandom_range(0, 1)) a = 6'($urandom_range(4, 15));
      reg_write(a, 8'($urandom), 1'b1);
      reg_read(6'($urandom_range(0, 17)));
    end

    // Reset in the middle of an RX packet.
    tick;
    bus.s_axis_tvalid_i = 1'b1;
    bus.s_axis_tdata_i = 8'h55;
    bus.s_axis_tlast_i = 1'b0;
    repeat (3) tick;
    areset_n = 1'b0;
    #1;
    chk("mid_rst_dir", {bus.ulpi_dir_o, bus.ulpi_nxt_o}, 2'b00);
    chk("mid_rst_data", bus.ulpi_data_o, 8'h00);
    chk("mid_rst_tready", bus.s_axis_tready_o, 0);
    chk("mid_rst_func", func_ctrl, 8'h41);
    chk("mid_rst_otg", otg_ctrl, 8'h06);
    bus.s_axis_tvalid_i = 1'b0;
    tick;
    areset_n = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
